// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential binary-to-packed-BCD converter using the shift-and-add-3
//   (double-dabble) method. One binary bit is consumed per clock, so a
//   conversion takes BIN_W cycles after the start is accepted. The digit
//   count is independent of the binary width. Values that do not fit in
//   DIGITS digits are flagged. They are either reduced modulo 10^DIGITS
//   or saturated to all nines.
//
// Parameters
//   BIN_W    : binary operand width (>= 1)
//   DIGITS   : number of BCD output digits (>= 1)
//   SATURATE : 1 = overflowing results read as all nines,
//              0 = overflowing results keep the low DIGITS digits
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous reset, active high; aborts a running conversion
//   start    : conversion request, taken only while idle
//   bin_in   : unsigned operand, captured on the accepting edge
//   busy     : conversion in progress
//   done     : one-cycle pulse when bcd_out/overflow take a new result
//   bcd_out  : packed BCD result, most significant digit in the top nibble
//   overflow : last result exceeded 10^DIGITS-1

// Per-digit correction applied before each shift. A digit of 5..9 becomes
// 8..12, so doubling it carries into the next digit exactly as a decimal
// doubling would. The add is confined to the nibble. No inter-digit carry
// is possible because 9+3 still fits in 4 bits.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end
endmodule

module bin_to_bcd_seq #(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overflow
);
    localparam int BCD_W = 4 * DIGITS;
    // The counter must be able to hold BIN_W itself, not only BIN_W-1.
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [0:0]       state;
    logic [BIN_W-1:0] shreg;     // remaining binary bits, MSB leaves first
    logic [BCD_W-1:0] scratch;   // BCD digits being built
    logic [CNT_W-1:0] cnt;       // shifts still to perform
    logic             sticky;    // a 1 has been shifted out of the top digit

    logic [DIGITS-1:0][3:0] dig_adj;
    logic [BCD_W-1:0]       scratch_adj;
    logic [BCD_W-1:0]       scratch_nxt;
    logic                   sticky_nxt;
    logic                   last_shift;

    // Correct every digit in parallel, then treat the corrected scratch as
    // one wide shift register with the binary operand appended below it.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit_adj u_adj (
                .din  (scratch[4*g +: 4]),
                .dout (dig_adj[g])
            );
        end
    endgenerate

    // Packed [DIGITS-1:0][3:0] flattens with digit 0 in the low nibble.
    assign scratch_adj = dig_adj;
    assign scratch_nxt = {scratch_adj[BCD_W-2:0], shreg[BIN_W-1]};

    // A set bit leaving the top digit means the corrected top digit was at
    // least 8. That is only possible when the digit was at least 5 before
    // correction, so the doubled value reached 10^DIGITS. This makes the
    // flag exact, not a heuristic.
    assign sticky_nxt = sticky | scratch_adj[BCD_W-1];
    assign last_shift = (cnt == CNT_ONE);

    assign busy = (state == S_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CNT_LOAD;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch <= scratch_nxt;
                    shreg   <= shreg << 1;
                    sticky  <= sticky_nxt;
                    cnt     <= cnt - CNT_ONE;
                    if (last_shift) begin
                        // Publish straight from the next-state values so the
                        // result lands on the same edge as the final shift.
                        state    <= S_IDLE;
                        done     <= 1'b1;
                        overflow <= sticky_nxt;
                        bcd_out  <= ((SATURATE != 0) && sticky_nxt) ? ALL_NINES
                                                                    : scratch_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;
    localparam int NI = 5;

    // Instance configurations: {BIN_W, DIGITS, SATURATE}
    int pw[NI] = '{8, 8, 8, 16, 1};
    int pd[NI] = '{3, 2, 2, 5, 1};
    int ps[NI] = '{0, 1, 0, 0, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [NI-1:0] st = '0;
    logic [15:0] bn[NI];

    wire  [NI-1:0] busy_w, done_w, ovf_w;
    wire  [11:0] q0;
    wire  [7:0]  q1, q2;
    wire  [19:0] q3;
    wire  [3:0]  q4;
    wire  [19:0] bcd_w[NI];

    assign bcd_w[0] = {8'h0, q0};
    assign bcd_w[1] = {12'h0, q1};
    assign bcd_w[2] = {12'h0, q2};
    assign bcd_w[3] = q3;
    assign bcd_w[4] = {16'h0, q4};

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SATURATE(0)) u_d0 (
        .clk(clk), .reset(reset), .start(st[0]), .bin_in(bn[0][7:0]),
        .busy(busy_w[0]), .done(done_w[0]), .bcd_out(q0), .overflow(ovf_w[0]));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .SATURATE(1)) u_d1 (
        .clk(clk), .reset(reset), .start(st[1]), .bin_in(bn[1][7:0]),
        .busy(busy_w[1]), .done(done_w[1]), .bcd_out(q1), .overflow(ovf_w[1]));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .SATURATE(0)) u_d2 (
        .clk(clk), .reset(reset), .start(st[2]), .bin_in(bn[2][7:0]),
        .busy(busy_w[2]), .done(done_w[2]), .bcd_out(q2), .overflow(ovf_w[2]));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SATURATE(0)) u_d3 (
        .clk(clk), .reset(reset), .start(st[3]), .bin_in(bn[3]),
        .busy(busy_w[3]), .done(done_w[3]), .bcd_out(q3), .overflow(ovf_w[3]));
    bin_to_bcd_seq #(.BIN_W(1), .DIGITS(1), .SATURATE(0)) u_d4 (
        .clk(clk), .reset(reset), .start(st[4]), .bin_in(bn[4][0:0]),
        .busy(busy_w[4]), .done(done_w[4]), .bcd_out(q4), .overflow(ovf_w[4]));

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [63:0] pow10(input int d);
        logic [63:0] p = 64'd1;
        for (int k = 0; k < d; k++) p = p * 10;
        return p;
    endfunction

    // Decimal digits of the value, written as nibbles; saturation clamps the
    // value to the largest representable number, otherwise keep it mod 10^d.
    function automatic logic [19:0] exp_bcd(input logic [63:0] v, input int d, input int s);
        logic [19:0] r = '0;
        logic [63:0] x;
        if (s != 0 && v > pow10(d) - 1) x = pow10(d) - 1;
        else x = v % pow10(d);
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    longint      cyc = 0;
    logic        m_busy[NI], m_done[NI], m_ovf[NI];
    logic [19:0] m_bcd[NI];
    longint      m_due[NI];
    logic [63:0] m_val[NI];

    // Result appears BIN_W edges after the accepting edge; starts while busy
    // are dropped; reset clears everything.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_ovf[i]  <= 1'b0;
                m_bcd[i]  <= '0;
            end else begin
                m_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (st[i]) begin
                        m_busy[i] <= 1'b1;
                        m_due[i]  <= cyc + pw[i];
                        m_val[i]  <= 64'(bn[i]) & ((64'd1 << pw[i]) - 1);
                    end
                end else if (cyc == m_due[i]) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_ovf[i]  <= (m_val[i] > pow10(pd[i]) - 1);
                    m_bcd[i]  <= exp_bcd(m_val[i], pd[i], ps[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("u%0d.busy", i), 64'(busy_w[i]), 64'(m_busy[i]));
                check($sformatf("u%0d.done", i), 64'(done_w[i]), 64'(m_done[i]));
                check($sformatf("u%0d.bcd", i), 64'(bcd_w[i]), 64'(m_bcd[i]));
                check($sformatf("u%0d.ovf", i), 64'(ovf_w[i]), 64'(m_ovf[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issue one conversion and count edges from acceptance to done. bin_in
    // is scrambled while busy to show it is ignored.
    task automatic run_conv(input int i, input logic [15:0] v, output int lat);
        @(negedge clk);
        st[i] = 1'b1;
        bn[i] = v;
        @(negedge clk);
        st[i] = 1'b0;
        lat = 0;
        while (!done_w[i] && lat < 40) begin
            bn[i] = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!done_w[i]) check($sformatf("u%0d.timeout", i), 64'(done_w[i]), 64'd1);
    endtask

    initial begin
        int lat, seen, r, i;
        logic [15:0] v, vmax;
        for (int k = 0; k < NI; k++) bn[k] = '0;
        reset = 1'b1;
        @(negedge clk);
        armed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset.busy", 64'(busy_w[0]), 64'd0);
        check("reset.bcd", 64'(q0), 64'd0);
        check("reset.ovf", 64'(ovf_w[0]), 64'd0);

        // 99 on defaults
        run_conv(0, 16'd99, lat);
        check("d99.lat", 64'(lat), 64'd8);
        check("d99.bcd", 64'(q0), 64'h099);
        check("d99.ovf", 64'(ovf_w[0]), 64'd0);

        // full sweep, next start issued in each done cycle
        @(negedge clk);
        st[0] = 1'b1;
        bn[0] = 16'd0;
        for (int k = 0; k < 256; k++) begin
            lat = 0;
            do begin @(negedge clk); lat++; end while (!done_w[0] && lat < 20);
            check("sweep.period", 64'(lat), 64'd9);
            if (k == 255) begin
                check("sweep.255", 64'(q0), 64'h255);
                st[0] = 1'b0;
            end else begin
                bn[0] = 16'(k + 1);
            end
        end

        // two digits, saturating
        run_conv(1, 16'd100, lat);
        check("sat100.bcd", 64'(q1), 64'h99);
        check("sat100.ovf", 64'(ovf_w[1]), 64'd1);
        run_conv(1, 16'd99, lat);
        check("sat99.bcd", 64'(q1), 64'h99);
        check("sat99.ovf", 64'(ovf_w[1]), 64'd0);
        run_conv(1, 16'd5, lat);
        check("sat5.bcd", 64'(q1), 64'h05);
        check("sat5.ovf", 64'(ovf_w[1]), 64'd0);

        // two digits, wrapping
        run_conv(2, 16'd255, lat);
        check("wrap255.bcd", 64'(q2), 64'h55);
        check("wrap255.ovf", 64'(ovf_w[2]), 64'd1);

        // start while busy is ignored
        @(negedge clk); st[0] = 1'b1; bn[0] = 16'd42;
        @(negedge clk); st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); st[0] = 1'b1; bn[0] = 16'd7;
        @(negedge clk); st[0] = 1'b0;
        lat = 0;
        while (!done_w[0] && lat < 20) begin @(negedge clk); lat++; end
        check("ignore.bcd", 64'(q0), 64'h042);
        @(negedge clk);
        check("ignore.idle", 64'(busy_w[0]), 64'd0);

        // wide instance
        run_conv(3, 16'd65535, lat);
        check("w16.lat", 64'(lat), 64'd16);
        check("w16.bcd", 64'(q3), 64'h65535);
        check("w16.ovf", 64'(ovf_w[3]), 64'd0);

        // single-bit instance
        run_conv(4, 16'd1, lat);
        check("w1.lat", 64'(lat), 64'd1);
        check("w1.bcd", 64'(q4), 64'h1);

        // randomized conversions including boundary values
        for (int n = 0; n < 60; n++) begin
            i = $urandom_range(0, NI - 1);
            vmax = 16'((64'd1 << pw[i]) - 1);
            r = $urandom_range(0, 9);
            case (r)
                0: v = 16'd0;
                1: v = vmax;
                2: v = 16'd99;
                3: v = 16'd100;
                4: v = 16'd999;
                5: v = 16'd1000;
                6: v = 16'd9;
                default: v = 16'($urandom);
            endcase
            v = v & vmax;
            run_conv(i, v, lat);
            check($sformatf("rand.u%0d.lat", i), 64'(lat), 64'(pw[i]));
        end

        // reset mid-conversion: no done, outputs cleared
        run_conv(0, 16'd123, lat);
        check("pre_abort.bcd", 64'(q0), 64'h123);
        @(negedge clk); st[0] = 1'b1; bn[0] = 16'd200;
        @(negedge clk); st[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_w[0]) seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", 64'(busy_w[0]), 64'd0);
        check("abort.bcd", 64'(q0), 64'd0);
        check("abort.ovf", 64'(ovf_w[0]), 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_w[0]) seen++;
        end
        check("abort.nodone", 64'(seen), 64'd0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
